// File: rtl/game_status_display.sv
// Multiplexed 4-digit 7-segment renderer for the game FSM status and step count.
// Snapshots inputs once per frame so a frame never shows a mix of old and new values.
module game_status_display #(
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned BLINK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_sw,
  input  logic [1:0] game_status,
  input  logic [5:0] step_number,
  output logic [3:0] an_n,
  output logic [7:0] seg_n,
  output logic       frame_tick
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_WIN  = 2'b10,
    ST_OVER = 2'b11
  } status_t;

  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic          primed;
  status_t       snap_status;
  logic [5:0]    snap_step;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  logic          tick, wrap, snap;
  logic [1:0]    idx_nxt;
  status_t       view_status;
  logic [5:0]    view_step;
  logic [3:0]    tens, ones;
  logic [FW-1:0] frame_nxt;
  logic          phase_nxt;
  logic [7:0]    digit_code;
  logic [7:0]    seg_nxt;

  function automatic logic [7:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 8'hC0;
      4'd1:    digit_seg = 8'hF9;
      4'd2:    digit_seg = 8'hA4;
      4'd3:    digit_seg = 8'hB0;
      4'd4:    digit_seg = 8'h99;
      4'd5:    digit_seg = 8'h92;
      4'd6:    digit_seg = 8'h82;
      4'd7:    digit_seg = 8'hF8;
      4'd8:    digit_seg = 8'h80;
      4'd9:    digit_seg = 8'h90;
      default: digit_seg = 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] glyph_seg(input status_t s);
    case (s)
      ST_IDLE: glyph_seg = 8'hBF;
      ST_RUN:  glyph_seg = 8'hAF;
      ST_WIN:  glyph_seg = 8'hC1;
      ST_OVER: glyph_seg = 8'h86;
      default: glyph_seg = 8'hFF;
    endcase
  endfunction

  always_comb begin
    tick    = (scan_cnt == SCAN_LAST);
    wrap    = tick && (idx == 2'd3);
    snap    = tick && (wrap || !primed);
    idx_nxt = idx + 2'd1;

    // Content rendered on a snapshot edge must come from the values being latched
    view_status = snap ? status_t'(game_status) : snap_status;
    view_step   = snap ? step_number : snap_step;

    if      (view_step >= 6'd60) tens = 4'd6;
    else if (view_step >= 6'd50) tens = 4'd5;
    else if (view_step >= 6'd40) tens = 4'd4;
    else if (view_step >= 6'd30) tens = 4'd3;
    else if (view_step >= 6'd20) tens = 4'd2;
    else if (view_step >= 6'd10) tens = 4'd1;
    else                         tens = 4'd0;
    ones = 4'(view_step - 6'(tens) * 6'd10);

    // Blink timing only runs across consecutive WIN frames; anything else restarts it visible
    frame_nxt = frame_cnt;
    phase_nxt = blink_phase;
    if (wrap) begin
      if (view_status != ST_WIN || snap_status != ST_WIN) begin
        frame_nxt = '0;
        phase_nxt = 1'b0;
      end else if (frame_cnt == BLINK_LAST) begin
        frame_nxt = '0;
        phase_nxt = ~blink_phase;
      end else begin
        frame_nxt = frame_cnt + 1'b1;
      end
    end

    case (idx_nxt)
      2'd0:    digit_code = digit_seg(ones);
      2'd1:    digit_code = (tens == 4'd0) ? 8'hFF : digit_seg(tens);
      2'd2:    digit_code = 8'hFF;
      default: digit_code = glyph_seg(view_status);
    endcase
    seg_nxt = (view_status == ST_WIN && phase_nxt) ? 8'hFF : digit_code;
  end

  always_ff @(posedge clk or negedge rst_sw) begin
    if (!rst_sw) begin
      scan_cnt    <= '0;
      idx         <= '0;
      primed      <= 1'b0;
      snap_status <= ST_IDLE;
      snap_step   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      an_n        <= '1;
      seg_n       <= '1;
      frame_tick  <= 1'b0;
    end else begin
      scan_cnt   <= tick ? '0 : scan_cnt + 1'b1;
      frame_tick <= wrap;
      if (tick) begin
        idx    <= idx_nxt;
        primed <= 1'b1;
        an_n   <= ~(4'b0001 << idx_nxt);
        seg_n  <= seg_nxt;
      end
      if (snap) begin
        snap_status <= view_status;
        snap_step   <= view_step;
      end
      frame_cnt   <= frame_nxt;
      blink_phase <= phase_nxt;
    end
  end

endmodule

// File: tb/tb_game_status_display.sv
// Directed bench for game_status_display: scan order, digit codes, snapshot timing, blink, async reset.
module tb_game_status_display;

  logic       clk = 1'b0;
  logic       rst_sw;
  logic [1:0] game_status;
  logic [5:0] step_number;
  logic [3:0] an_n;
  logic [7:0] seg_n;
  logic       frame_tick;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  game_status_display #(
    .SCAN_DIV(4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst_sw(rst_sw),
    .game_status(game_status),
    .step_number(step_number),
    .an_n(an_n),
    .seg_n(seg_n),
    .frame_tick(frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic slot(input string tag, input logic [3:0] ea, input logic [7:0] es);
    cyc(4);
    check({tag, ".an"}, 32'(an_n), 32'(ea));
    check({tag, ".seg"}, 32'(seg_n), 32'(es));
  endtask

  // Starts at the digit0 sample point; d1..d3 show the previous snapshot, d0 the next one
  task automatic run_frame(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                           input logic [7:0] e3, input logic [7:0] e0);
    slot({tag, ".d1"}, 4'hD, e1);
    check({tag, ".ft_lo"}, 32'(frame_tick), 32'd0);
    slot({tag, ".d2"}, 4'hB, e2);
    slot({tag, ".d3"}, 4'h7, e3);
    slot({tag, ".d0"}, 4'hE, e0);
    check({tag, ".ft_hi"}, 32'(frame_tick), 32'd1);
  endtask

  // Release at a falling edge, then expect three dark samples followed by the first frame
  task automatic powerup(input string tag, input logic [7:0] e3, input logic [7:0] e0);
    @(negedge clk);
    rst_sw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check({tag, ".dark_an"}, 32'(an_n), 32'hF);
      check({tag, ".dark_seg"}, 32'(seg_n), 32'hFF);
    end
    cyc(1);
    check({tag, ".d1.an"}, 32'(an_n), 32'hD);
    check({tag, ".d1.seg"}, 32'(seg_n), 32'hFF);
    check({tag, ".d1.ft"}, 32'(frame_tick), 32'd0);
    slot({tag, ".d2"}, 4'hB, 8'hFF);
    slot({tag, ".d3"}, 4'h7, e3);
    slot({tag, ".d0"}, 4'hE, e0);
    check({tag, ".d0.ft"}, 32'(frame_tick), 32'd1);
  endtask

  initial begin
    int unsigned viol;
    rst_sw      = 1'b0;
    game_status = 2'b01;
    step_number = 6'd0;
    cyc(3);
    check("rst.an", 32'(an_n), 32'hF);
    check("rst.seg", 32'(seg_n), 32'hFF);
    check("rst.ft", 32'(frame_tick), 32'd0);

    powerup("pu1", 8'hAF, 8'hC0);
    cyc(1);
    check("pu1.ft_one_cycle", 32'(frame_tick), 32'd0);
    cyc(3);
    check("pu1.f1.d1", 32'(seg_n), 32'hFF);
    slot("pu1.f1.d2", 4'hB, 8'hFF);
    slot("pu1.f1.d3", 4'h7, 8'hAF);
    slot("pu1.f1.d0", 4'hE, 8'hC0);

    step_number = 6'd47;
    run_frame("s47a", 8'hFF, 8'hFF, 8'hAF, 8'hF8);
    run_frame("s47b", 8'h99, 8'hFF, 8'hAF, 8'hF8);
    step_number = 6'd9;
    run_frame("s9a", 8'h99, 8'hFF, 8'hAF, 8'h90);
    run_frame("s9b", 8'hFF, 8'hFF, 8'hAF, 8'h90);
    step_number = 6'd63;
    run_frame("s63a", 8'hFF, 8'hFF, 8'hAF, 8'hB0);
    run_frame("s63b", 8'h82, 8'hFF, 8'hAF, 8'hB0);
    step_number = 6'd5;
    run_frame("s5", 8'h82, 8'hFF, 8'hAF, 8'h92);

    slot("tear.d1", 4'hD, 8'hFF);
    step_number = 6'd12;
    slot("tear.d2", 4'hB, 8'hFF);
    slot("tear.d3", 4'h7, 8'hAF);
    slot("tear.d0", 4'hE, 8'hA4);
    run_frame("s12", 8'hF9, 8'hFF, 8'hAF, 8'hA4);

    game_status = 2'b10;
    run_frame("win0", 8'hF9, 8'hFF, 8'hAF, 8'hA4);
    run_frame("win1", 8'hF9, 8'hFF, 8'hC1, 8'hA4);
    run_frame("win2", 8'hF9, 8'hFF, 8'hC1, 8'hFF);
    run_frame("win3", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run_frame("win4", 8'hFF, 8'hFF, 8'hFF, 8'hA4);
    run_frame("win5", 8'hF9, 8'hFF, 8'hC1, 8'hA4);
    run_frame("win6", 8'hF9, 8'hFF, 8'hC1, 8'hFF);
    game_status = 2'b11;
    run_frame("over0", 8'hFF, 8'hFF, 8'hFF, 8'hA4);
    run_frame("over1", 8'hF9, 8'hFF, 8'h86, 8'hA4);

    slot("pre_rst.d1", 4'hD, 8'hF9);
    slot("pre_rst.d2", 4'hB, 8'hFF);
    #2;
    rst_sw = 1'b0;
    #1;
    check("async.an", 32'(an_n), 32'hF);
    check("async.seg", 32'(seg_n), 32'hFF);
    check("async.ft", 32'(frame_tick), 32'd0);
    game_status = 2'b00;
    step_number = 6'd0;
    cyc(2);
    powerup("pu2", 8'hBF, 8'hC0);
    run_frame("idle", 8'hFF, 8'hFF, 8'hBF, 8'hC0);

    viol = 0;
    for (int f = 0; f < 100; f++) begin
      for (int c = 0; c < 16; c++) begin
        if ($urandom_range(7) == 0) begin
          game_status = 2'($urandom_range(3));
          step_number = 6'($urandom_range(63));
        end
        cyc(1);
        if (!(an_n == 4'hE || an_n == 4'hD || an_n == 4'hB || an_n == 4'h7)) viol++;
      end
    end
    check("onehot_violations", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
